// File: rtl/cic_prog_decim.sv
`default_nettype none
// ============================================================================
// Module   : cic_prog_decim
// Brief    : CIC decimator, run-time 2^k ratio, ratio-independent gain,
//            flush/settle sequencing after every reconfiguration.
// Revision : 1.0
// ============================================================================
module cic_prog_decim #(
  parameter int IN_W       = 2,
  parameter int ORDER      = 5,
  parameter int MIN_R_LOG2 = 2,
  parameter int MAX_R_LOG2 = 7,
  parameter int RST_R_LOG2 = 5,
  parameter int OUT_W      = 33,
  localparam int ACC_W     = IN_W + ORDER * MAX_R_LOG2,
  localparam int RW        = $clog2(MAX_R_LOG2 + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  data_in,
  input  logic                    in_valid,
  input  logic [RW-1:0]           cfg_ratio_log2,
  input  logic                    cfg_load,
  output logic signed [OUT_W-1:0] data_out,
  output logic                    valid_out,
  output logic                    busy,
  output logic                    cfg_err
);

  localparam int             DW    = $clog2(ORDER + 1);
  localparam logic [RW-1:0]  MIN_K = RW'(MIN_R_LOG2);
  localparam logic [RW-1:0]  MAX_K = RW'(MAX_R_LOG2);
  localparam logic [ACC_W:0] RND   = (ACC_W + 1)'(1) << (ACC_W - OUT_W - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t                  state_q;
  logic [RW-1:0]           ratio_q;
  logic [DW-1:0]           discard_q;
  logic [ACC_W-1:0]        integ_q [ORDER];
  logic [ACC_W-1:0]        dly_q   [ORDER];
  logic [MAX_R_LOG2-1:0]   cnt_q;
  logic                    comb_stb_q;
  logic                    comb_vld_q;
  logic [ACC_W-1:0]        comb_q;
  logic signed [OUT_W-1:0] data_out_q;
  logic                    valid_out_q;
  logic                    busy_q;
  logic                    cfg_err_q;

  logic                    w_k_ok;
  logic                    w_flush;
  logic                    w_last;
  logic [MAX_R_LOG2-1:0]   w_mask;
  logic [15:0]             w_sh;
  logic [ACC_W-1:0]        w_in_ext;
  logic [ACC_W-1:0]        w_comb;
  logic [ACC_W-1:0]        w_stage_in [ORDER];
  logic [ACC_W:0]          w_rnd;
  logic [OUT_W:0]          w_top;
  logic [OUT_W-1:0]        w_sat;

  assign w_k_ok   = cfg_load && (cfg_ratio_log2 >= MIN_K) && (cfg_ratio_log2 <= MAX_K);
  assign w_flush  = (state_q == ST_FLUSH);
  assign w_mask   = ~({MAX_R_LOG2{1'b1}} << ratio_q);
  assign w_last   = (cnt_q == w_mask);
  assign w_sh     = 16'(ORDER) * (16'(MAX_R_LOG2) - 16'(ratio_q));
  assign w_in_ext = {{(ACC_W - IN_W){data_in[IN_W-1]}}, data_in};

  // Differentiator chain evaluated in one pass on the comb strobe.
  always_comb begin
    w_comb = integ_q[ORDER-1];
    for (int i = 0; i < ORDER; i++) begin
      w_stage_in[i] = w_comb;
      w_comb        = w_comb - dly_q[i];
    end
  end

  // Rounding can only push upwards, but the saturation is kept symmetric.
  assign w_rnd = {comb_q[ACC_W-1], comb_q} + RND;
  assign w_top = w_rnd[ACC_W -: OUT_W + 1];
  assign w_sat = (w_top[OUT_W] != w_top[OUT_W-1]) ?
                 {w_top[OUT_W], {(OUT_W - 1){~w_top[OUT_W]}}} : w_top[OUT_W-1:0];

  // Integrators are pipelined (each stage adds the previous stage's old value);
  // this is a pure delay of the filter and keeps carry chains short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ORDER; i++) begin
        integ_q[i] <= '0;
        dly_q[i]   <= '0;
      end
      cnt_q      <= '0;
      comb_stb_q <= 1'b0;
      comb_vld_q <= 1'b0;
      comb_q     <= '0;
    end else if (w_flush) begin
      for (int i = 0; i < ORDER; i++) begin
        integ_q[i] <= '0;
        dly_q[i]   <= '0;
      end
      cnt_q      <= '0;
      comb_stb_q <= 1'b0;
      comb_vld_q <= 1'b0;
      comb_q     <= '0;
    end else begin
      comb_stb_q <= 1'b0;
      comb_vld_q <= 1'b0;
      if (in_valid) begin
        integ_q[0] <= integ_q[0] + w_in_ext;
        for (int i = 1; i < ORDER; i++) begin
          integ_q[i] <= integ_q[i] + integ_q[i-1];
        end
        cnt_q      <= w_last ? '0 : cnt_q + MAX_R_LOG2'(1);
        comb_stb_q <= w_last;
      end
      if (comb_stb_q) begin
        for (int i = 0; i < ORDER; i++) begin
          dly_q[i] <= w_stage_in[i];
        end
        comb_q     <= w_comb << w_sh;
        comb_vld_q <= 1'b1;
      end
    end
  end

  // A legal load overrides everything else in its cycle, including a result
  // that would otherwise be presented on that same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SETTLE;
      ratio_q     <= RW'(RST_R_LOG2);
      discard_q   <= DW'(ORDER);
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      busy_q      <= 1'b1;
      cfg_err_q   <= 1'b0;
    end else begin
      valid_out_q <= 1'b0;
      if (w_k_ok) begin
        state_q   <= ST_FLUSH;
        ratio_q   <= cfg_ratio_log2;
        cfg_err_q <= 1'b0;
        busy_q    <= 1'b1;
      end else begin
        if (cfg_load) begin
          cfg_err_q <= 1'b1;
        end
        case (state_q)
          ST_FLUSH: begin
            state_q   <= ST_SETTLE;
            discard_q <= DW'(ORDER);
          end
          ST_SETTLE: begin
            if (comb_vld_q) begin
              if (discard_q == '0) begin
                state_q     <= ST_RUN;
                busy_q      <= 1'b0;
                valid_out_q <= 1'b1;
                data_out_q  <= w_sat;
              end else begin
                discard_q <= discard_q - DW'(1);
              end
            end
          end
          default: begin
            if (comb_vld_q) begin
              valid_out_q <= 1'b1;
              data_out_q  <= w_sat;
            end
          end
        endcase
      end
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign busy      = busy_q;
  assign cfg_err   = cfg_err_q;

endmodule
`default_nettype wire

// File: doc/cic_prog_decim.md
Name: cic_prog_decim

Overview:
- Parametrised, runtime-programmable CIC decimator for the sigma-delta decimation path.
- Generalises the fixed x32 CIC front end: order, input width and maximum ratio are parameters; the ratio 2^k is selected at run time.
- Output gain is normalised so full-scale is independent of the selected ratio.
- A flush/settle FSM discards transient samples after every reconfiguration; downstream halfband stages therefore see only settled data.

Parameters:
- IN_W, 2, signed input sample width (modulator output).
- ORDER, 5, number of integrator and comb stages.
- MIN_R_LOG2, 2, smallest legal log2(decimation ratio).
- MAX_R_LOG2, 7, largest legal log2(decimation ratio), i.e. max ratio 128.
- RST_R_LOG2, 5, ratio loaded at reset (x32).
- OUT_W, 33, signed output width.
- Derived ACC_W = IN_W + ORDER*MAX_R_LOG2 (37 at defaults); RW = clog2(MAX_R_LOG2+1).

Ports:
- clk  in  1  system clock, modulator rate.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  IN_W  signed input sample.
- in_valid  in  1  input sample strobe, acts as clock enable.
- cfg_ratio_log2  in  RW  requested log2 ratio, sampled only when cfg_load=1.
- cfg_load  in  1  one-cycle request to apply cfg_ratio_log2.
- data_out  out  OUT_W  signed, normalised, rounded output.
- valid_out  out  1  one-cycle pulse per output sample.
- busy  out  1  high during FLUSH/SETTLE.
- cfg_err  out  1  sticky: last cfg_load carried an illegal ratio.

Behaviour:
- Reset (async): integrators, combs, decimation counter, data_out = 0; valid_out = 0; cfg_err = 0; ratio = RST_R_LOG2; FSM = SETTLE with discard count = ORDER; busy = 1.
- Integrators are ACC_W wide and wrap modulo 2^ACC_W (no saturation). They update only on in_valid=1. Input is sign-extended to ACC_W.
- Decimation counter counts accepted samples 0..2^k-1 and wraps. When the sample at count 2^k-1 is accepted, a comb strobe is issued on the next cycle.
- Comb strobe:
  - The last integrator output feeds a chain of ORDER differentiators (ACC_W wide, wrapping), each with a single delay register.
  - The comb result is left-shifted by ORDER*(MAX_R_LOG2-k), so DC gain is 2^(ORDER*MAX_R_LOG2) for every k.
- Requantise: keep the top OUT_W bits of ACC_W, round half up by adding 1 at bit ACC_W-OUT_W-1, and saturate to the OUT_W signed range. This is registered.
- Latency: valid_out is high in the cycle 3 clk after the cycle that accepted the period-completing sample. data_out holds its value until the next valid_out.
- Gaps in in_valid stretch the period; latency counts from acceptance, not from the start of the period.
- FSM:
  - RUN: outputs pass through.
  - cfg_load with a legal k (MIN..MAX) goes to FLUSH. The new ratio is latched and cfg_err is cleared.
  - cfg_load with an illegal k sets cfg_err. Ratio and state are unchanged, with no flush.
  - FLUSH (1 cycle): clears integrators, combs, counter and the pipeline, and drops any in-flight result. The in_valid sample in this cycle is discarded. Then go to SETTLE with discard count = ORDER.
  - SETTLE: the pipeline runs, but valid_out is suppressed for ORDER comb results; then go to RUN.
  - busy = 1 in FLUSH and SETTLE.
- cfg_load during FLUSH/SETTLE: a legal k restarts FLUSH with the new k; an illegal k sets cfg_err only.
- cfg_load and the period-completing sample in the same cycle: the load wins and that result is never output.
- Reset mid-operation: immediate return to the reset state. Any pending valid_out is lost.

Test Plan:
- Reset, then constant data_in=+1 with in_valid=1 and default k=5: first valid_out after 6 periods (~192+3 clk); data_out=2147483648 (2^31) thereafter; busy drops with the first valid_out.
- cfg_load k=7 with constant +1: busy=1; next valid_out comes ORDER+1 periods of 128 samples later; data_out=2^31 (ratio-independent).
- Constant data_in=-2 at k=2 (after settle): data_out=-4294967296 (-2^32), with no saturation error, i.e. the exact min value.
- Alternating +1/-1 at k=5: data_out=0 after settle.
- in_valid toggling 1/0 at k=3: valid_out every 16 clk; each pulse exactly 3 clk after the accepting cycle.
- cfg_load k=8, then k=1: cfg_err=1 and stays high; ratio unchanged (valid_out period unchanged); a following cfg_load k=4 clears cfg_err and triggers a flush.
- Assert rst mid-period: all outputs 0 at once; busy=1; ratio back to 5.
